// File: rtl/gpio_capture_ctrl_if.sv
// Register-bus interface for gpio_capture_ctrl.
// The master drives write/read requests and the slave returns read responses.
interface gpio_capture_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             wr_en;
  logic             rd_en;
  logic [1:0]       addr;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             rd_valid;

  modport master (
    output wr_en, rd_en, addr, data_in,
    input  data_out, rd_valid
  );

  modport slave (
    input  wr_en, rd_en, addr, data_in,
    output data_out, rd_valid
  );
endinterface

// File: rtl/gpio_capture_ctrl.sv
// GPIO capture block: synchronized pins, direct or Ext_clk-edge capture, sticky change interrupt.
// Optional macro GPIO_GLITCH_FILTER_EN adds a 3-sample agreement filter on the synced pins.
module gpio_capture_ctrl #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [WIDTH-1:0]    i_gpio,
  input  logic                i_ext_clk,
  gpio_capture_ctrl_if.slave  bus,
  output logic                o_int
);

  localparam logic [1:0] ADDR_USE_EXT  = 2'd0;
  localparam logic [1:0] ADDR_EDGE_SEL = 2'd1;
  localparam logic [1:0] ADDR_CAPTURED = 2'd2;
  localparam logic [1:0] ADDR_INT_MASK = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_gpio_sync;
  logic [SYNC_STAGES-1:0]            r_ext_sync;
  logic                              r_ext_prev;

  logic [WIDTH-1:0] r_use_ext;
  logic [WIDTH-1:0] r_edge_sel;
  logic [WIDTH-1:0] r_int_mask;
  logic [WIDTH-1:0] r_captured;
  logic [WIDTH-1:0] r_pend;
  logic [WIDTH-1:0] r_data_out;
  logic [1:0]       r_rd_addr;
  state_t           r_state;

  logic [WIDTH-1:0] w_gpio_synced;
  logic [WIDTH-1:0] w_gpio_filt;
  logic             w_ext_synced;
  logic             w_ext_rise;
  logic             w_ext_fall;
  logic [WIDTH-1:0] w_cap_sel;
  logic [WIDTH-1:0] w_cap_next;
  logic [WIDTH-1:0] w_pend_set;
  logic             w_pend_clr;
  logic [WIDTH-1:0] w_rd_mux;
  state_t           w_state_next;
  logic             w_rd_valid;
  logic             w_rd_latch;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_gpio_sync <= '0;
      r_ext_sync  <= '0;
      r_ext_prev  <= 1'b0;
    end else begin
      r_gpio_sync <= {r_gpio_sync[SYNC_STAGES-2:0], i_gpio};
      r_ext_sync  <= {r_ext_sync[SYNC_STAGES-2:0], i_ext_clk};
      r_ext_prev  <= r_ext_sync[SYNC_STAGES-1];
    end
  end

  assign w_gpio_synced = r_gpio_sync[SYNC_STAGES-1];
  assign w_ext_synced  = r_ext_sync[SYNC_STAGES-1];
  assign w_ext_rise    = w_ext_synced & ~r_ext_prev;
  assign w_ext_fall    = ~w_ext_synced & r_ext_prev;

`ifdef GPIO_GLITCH_FILTER_EN
  logic [WIDTH-1:0] r_filt_h1;
  logic [WIDTH-1:0] r_filt_h2;
  logic [WIDTH-1:0] r_filt_val;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_filt_h1  <= '0;
      r_filt_h2  <= '0;
      r_filt_val <= '0;
    end else begin
      r_filt_h1  <= w_gpio_synced;
      r_filt_h2  <= r_filt_h1;
      r_filt_val <= w_gpio_filt;
    end
  end

  // A bit is accepted once the current synced sample and the two before it agree.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_filt
    assign w_gpio_filt[gi] = ((w_gpio_synced[gi] == r_filt_h1[gi]) && (r_filt_h1[gi] == r_filt_h2[gi]))
                             ? w_gpio_synced[gi] : r_filt_val[gi];
  end
`else
  assign w_gpio_filt = w_gpio_synced;
`endif

  // Config registers in effect this cycle govern capture, so a write racing an edge pulse loses.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cap
    assign w_cap_sel[gi]  = ~r_use_ext[gi] | (r_edge_sel[gi] ? w_ext_rise : w_ext_fall);
    assign w_cap_next[gi] = w_cap_sel[gi] ? w_gpio_filt[gi] : r_captured[gi];
  end

  assign w_pend_set = (w_cap_next ^ r_captured) & r_int_mask;
  assign w_pend_clr = (r_state == ST_RESP) && (r_rd_addr == ADDR_CAPTURED);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_captured <= '0;
      r_pend     <= '0;
    end else begin
      r_captured <= w_cap_next;
      r_pend     <= (w_pend_clr ? '0 : r_pend) | w_pend_set;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_use_ext  <= '0;
      r_edge_sel <= '0;
      r_int_mask <= '0;
    end else if (bus.wr_en) begin
      case (bus.addr)
        ADDR_USE_EXT:  r_use_ext  <= bus.data_in;
        ADDR_EDGE_SEL: r_edge_sel <= bus.data_in;
        ADDR_INT_MASK: r_int_mask <= bus.data_in;
        default:       ;
      endcase
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (bus.addr)
      ADDR_USE_EXT:  w_rd_mux = r_use_ext;
      ADDR_EDGE_SEL: w_rd_mux = r_edge_sel;
      ADDR_CAPTURED: w_rd_mux = r_captured;
      ADDR_INT_MASK: w_rd_mux = r_int_mask;
      default:       w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_rd_valid   = 1'b0;
    w_rd_latch   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.rd_en) begin
          w_state_next = ST_RESP;
          w_rd_latch   = 1'b1;
        end
      end
      ST_RESP: begin
        w_rd_valid   = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data_out <= '0;
      r_rd_addr  <= '0;
    end else if (w_rd_latch) begin
      r_data_out <= w_rd_mux;
      r_rd_addr  <= bus.addr;
    end
  end

  assign bus.data_out = w_rd_valid ? r_data_out : '0;
  assign bus.rd_valid = w_rd_valid;
  assign o_int        = |r_pend;

endmodule

// File: tb/tb_gpio_capture_ctrl.sv
// Directed bench for gpio_capture_ctrl: capture modes, interrupt, read FSM, reset behavior.
// Expected latencies follow GPIO_GLITCH_FILTER_EN when it is defined.
module tb_gpio_capture_ctrl;
  localparam int WIDTH = 8;
`ifdef GPIO_GLITCH_FILTER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] gpio = '0;
  logic             ext_clk = 1'b0;
  logic             irq;
  logic [WIDTH-1:0] d;
  int               n_cmp = 0;
  int               n_err = 0;

  gpio_capture_ctrl_if #(.WIDTH(WIDTH)) bus ();

  gpio_capture_ctrl #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_gpio   (gpio),
    .i_ext_clk(ext_clk),
    .bus      (bus),
    .o_int    (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [WIDTH-1:0] v);
    bus.wr_en   = 1'b1;
    bus.addr    = a;
    bus.data_in = v;
    tick();
    bus.wr_en   = 1'b0;
    $display("write addr=%0d data=%02h", a, v);
  endtask

  task automatic rd(input logic [1:0] a, output logic [WIDTH-1:0] v);
    bus.rd_en = 1'b1;
    bus.addr  = a;
    tick();
    chk("rd_valid_resp", bus.rd_valid, 1);
    v = bus.data_out;
    bus.rd_en = 1'b0;
    tick();
    chk("rd_valid_idle", bus.rd_valid, 0);
    $display("read  addr=%0d data=%02h", a, v);
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = 2'd0; bus.data_in = '0;

    // Reset state, including a read request while reset is held
    repeat (3) tick();
    bus.rd_en = 1'b1;
    tick();
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_int", irq, 0);
    bus.rd_en = 1'b0;
    rst = 1'b0;
    tick();

    // Direct capture latency: not yet visible at edge k+LAT, visible afterwards
    gpio = 8'hA5;
    repeat (LAT) tick();
    rd(2'd2, d); chk("direct_early", d, 8'h00);
    rd(2'd2, d); chk("direct_a5", d, 8'hA5);
    chk("direct_int", irq, 0);
    gpio = 8'h5A;
    repeat (LAT + 1) tick();
    rd(2'd2, d); chk("direct_5a_ontime", d, 8'h5A);

    // External strobe capture
    gpio = 8'h00;
    repeat (LAT + 1) tick();
    wr(2'd0, 8'hFF);
    wr(2'd1, 8'h0F);
    rd(2'd0, d); chk("use_ext_rb", d, 8'hFF);
    rd(2'd1, d); chk("edge_sel_rb", d, 8'h0F);
    gpio = 8'h3C;
    repeat (LAT + 2) tick();
    rd(2'd2, d); chk("ext_hold", d, 8'h00);
    ext_clk = 1'b1;
    repeat (5) tick();
    rd(2'd2, d); chk("ext_rise", d, 8'h0C);
    ext_clk = 1'b0;
    repeat (5) tick();
    rd(2'd2, d); chk("ext_fall", d, 8'h3C);

    // Interrupt set and clear-on-read
    wr(2'd0, 8'h00);
    gpio = 8'h00;
    repeat (LAT + 1) tick();
    wr(2'd3, 8'h01);
    chk("int_idle", irq, 0);
    gpio = 8'h01;
    repeat (LAT) tick();
    chk("int_early", irq, 0);
    tick();
    chk("int_set", irq, 1);
    bus.rd_en = 1'b1; bus.addr = 2'd2;
    tick();
    chk("int_rd_valid", bus.rd_valid, 1);
    chk("int_rd_data", bus.data_out, 8'h01);
    chk("int_during_resp", irq, 1);
    bus.rd_en = 1'b0;
    tick();
    chk("int_rd_done", bus.rd_valid, 0);
    chk("int_cleared", irq, 0);

    // Masking keeps existing pending bits
    gpio = 8'h00;
    repeat (LAT + 1) tick();
    chk("int_reset_edge", irq, 1);
    wr(2'd3, 8'h00);
    chk("int_mask_keeps", irq, 1);
    rd(2'd2, d);
    chk("int_clear2", irq, 0);
    gpio = 8'h01;
    repeat (LAT + 1) tick();
    chk("int_masked", irq, 0);

    // Pending set on the clearing edge wins
    wr(2'd3, 8'h01);
    gpio = 8'h00;
    repeat (LAT - 1) tick();
    rd(2'd2, d); chk("race_data", d, 8'h01);
    chk("race_pend_wins", irq, 1);
    rd(2'd2, d);
    chk("race_cleared", irq, 0);

    // Back-to-back read requests yield one response
    bus.rd_en = 1'b1; bus.addr = 2'd0;
    tick();
    chk("b2b_first", bus.rd_valid, 1);
    tick();
    chk("b2b_second", bus.rd_valid, 0);
    bus.rd_en = 1'b0;
    tick();
    chk("b2b_after", bus.rd_valid, 0);

    // Same-cycle write and read to one address
    bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.addr = 2'd0; bus.data_in = 8'h55;
    tick();
    chk("rw_valid", bus.rd_valid, 1);
    chk("rw_old", bus.data_out, 8'h00);
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    tick();
    rd(2'd0, d); chk("rw_new", d, 8'h55);

    // Reset during a response
    wr(2'd0, 8'h00);
    wr(2'd3, 8'hFF);
    gpio = 8'hFF;
    repeat (LAT + 1) tick();
    chk("pre_rst_int", irq, 1);
    bus.rd_en = 1'b1; bus.addr = 2'd3;
    tick();
    chk("pre_rst_valid", bus.rd_valid, 1);
    chk("pre_rst_data", bus.data_out, 8'hFF);
    bus.rd_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", bus.rd_valid, 0);
    chk("midrst_data", bus.data_out, 0);
    chk("midrst_int", irq, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("postrst_valid1", bus.rd_valid, 0);
    tick();
    chk("postrst_valid2", bus.rd_valid, 0);
    rd(2'd2, d); chk("first_cap_after_rst", d, 8'h00);
    rd(2'd0, d); chk("rst_use_ext", d, 8'h00);
    rd(2'd1, d); chk("rst_edge_sel", d, 8'h00);
    rd(2'd3, d); chk("rst_int_mask", d, 8'h00);
    rd(2'd2, d); chk("cap_after_rst", d, 8'hFF);
    chk("rst_int_after", irq, 0);

    // Short pulses: rejected by the glitch filter when present
    gpio = 8'h00;
    repeat (8) tick();
    wr(2'd3, 8'h01);
    chk("pulse_int_idle", irq, 0);
`ifdef GPIO_GLITCH_FILTER_EN
    gpio = 8'h01;
    repeat (2) tick();
    gpio = 8'h00;
    repeat (8) tick();
    chk("filt_2cyc", irq, 0);
    gpio = 8'h01;
    repeat (3) tick();
    gpio = 8'h00;
    repeat (8) tick();
    chk("filt_3cyc", irq, 1);
`else
    gpio = 8'h01;
    tick();
    gpio = 8'h00;
    repeat (6) tick();
    chk("nofilt_1cyc", irq, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/gpio_capture_ctrl.md
GPIO_CAPTURE_CTRL -- requirements
Module: gpio_capture_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, number of GPIO pins captured.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth on Gpio and Ext_clk (legal 2..4).
REQ-003 Clk  input  1  sole clock; all state on rising edge.
REQ-004 Rst  input  1  asynchronous, active-high reset.
REQ-005 Gpio  input  WIDTH  asynchronous pin inputs.
REQ-006 Ext_clk  input  1  asynchronous external capture strobe.
REQ-007 Wr_en  input  1  register write strobe, one cycle.
REQ-008 Rd_en  input  1  register read request, one cycle.
REQ-009 Addr  input  2  register select: 0 USE_EXT, 1 EDGE_SEL, 2 CAPTURED (read-only), 3 INT_MASK.
REQ-010 Data_in  input  WIDTH  write data.
REQ-011 Data_out  output  WIDTH  read data, valid only while Rd_valid=1.
REQ-012 Rd_valid  output  1  read response pulse.
REQ-013 Int  output  1  level interrupt; high while any pending bit set.

Function
REQ-014 Gpio and Ext_clk each pass through a SYNC_STAGES flop synchronizer before any use.
REQ-015 One extra flop on synced Ext_clk yields rise/fall pulses, each exactly one cycle per transition.
REQ-016 Bit i with USE_EXT[i]=0: CAPTURED[i] loads synced Gpio[i] every cycle.
REQ-017 Bit i with USE_EXT[i]=1: CAPTURED[i] loads synced Gpio[i] only on Ext_clk rise (EDGE_SEL[i]=1) or fall (EDGE_SEL[i]=0) pulse; otherwise holds.
REQ-018 Direct-mode latency: Gpio change stable before Clk edge k appears in CAPTURED after edge k+SYNC_STAGES.
REQ-019 Any CAPTURED[i] change with INT_MASK[i]=1 sets sticky PEND[i]; Int = OR of PEND.
REQ-020 Write: Wr_en=1 updates register at Addr on same edge; writes to Addr 2 ignored; new config applies from next cycle.
REQ-021 Read FSM states IDLE, RESP; IDLE --Rd_en--> RESP (Data_out latched from Addr), RESP --> IDLE unconditionally.
REQ-022 Rd_valid=1 exactly in RESP; read latency one cycle; Rd_en during RESP ignored, no response.
REQ-023 Read of Addr 2 clears all PEND on RESP->IDLE edge; a PEND set on that same edge wins over clear.
REQ-024 Simultaneous Wr_en and Rd_en to same Addr: read returns pre-write value, write takes effect.
REQ-025 Changing USE_EXT/EDGE_SEL during an Ext_clk edge pulse: old setting governs that cycle.
REQ-026 Masking (INT_MASK[i] 1->0) does not clear existing PEND[i].

Reset
REQ-027 Rst=1 asynchronously clears synchronizers, edge flop, USE_EXT, EDGE_SEL, INT_MASK, CAPTURED, PEND to 0; FSM to IDLE.
REQ-028 During reset Data_out=0, Rd_valid=0, Int=0; reset mid-read aborts response, no Rd_valid after release.
REQ-029 First capture after Rst deassert occurs no earlier than SYNC_STAGES cycles later.

Configuration
REQ-030 Macro GPIO_GLITCH_FILTER_EN defined: each synced Gpio bit accepted only after 3 consecutive equal samples; direct latency grows by 2 cycles; Ext_clk unfiltered.
REQ-031 GPIO_GLITCH_FILTER_EN undefined: no filter logic; synced Gpio feeds capture directly.

Verification
REQ-032 Reset, USE_EXT=0, Gpio 0x00->0xA5 -> CAPTURED=0xA5 after 2 cycles (4 with filter); Int stays 0.
REQ-033 USE_EXT=0xFF, EDGE_SEL=0x0F, Gpio=0x3C, Ext_clk rise -> CAPTURED=0x0C; Ext_clk fall -> CAPTURED=0x3C.
REQ-034 INT_MASK=0x01, Gpio[0] toggles -> Int=1; read Addr 2 -> Rd_valid one cycle, Data_out=0x01, Int=0 next cycle.
REQ-035 Rd_en two consecutive cycles -> exactly one Rd_valid; same-cycle write 0x55/read Addr 0 -> read returns old 0x00, then 0x55.
REQ-036 Rst asserted during RESP -> Rd_valid drops immediately, all registers 0, no response after release.
REQ-037 With GPIO_GLITCH_FILTER_EN, 2-cycle Gpio pulse -> CAPTURED unchanged; 3-cycle pulse -> captured.
